// File: rtl/game_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// game_ctrl_pkg : shared game-state encodings and score width default
// Rev 1.0
// ----------------------------------------------------------------------------
package game_ctrl_pkg;

   // draw_* blocks decode the state bus with these same values
   typedef enum logic [1:0] {
      GS_IDLE = 2'd0,
      GS_RUN  = 2'd1,
      GS_HIT  = 2'd2,
      GS_OVER = 2'd3
   } game_state_t;

   localparam int SCORE_W_DEF = 16;

endpackage
`default_nettype wire

// File: rtl/game_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// game_ctrl_if : tick/button/collision inputs and display-control outputs
// Rev 1.0
// ----------------------------------------------------------------------------
interface game_ctrl_if
   import game_ctrl_pkg::*;
#(
   parameter int SCORE_W = SCORE_W_DEF
) ();

   logic               tick_frame;
   logic               tick_score;
   logic               start;
   logic               collide;
   logic               run_en;
   logic               flash;
   logic [SCORE_W-1:0] score;
   logic [SCORE_W-1:0] hi_score;
   logic               new_hi;
   logic [1:0]         state;

   modport master (
      output tick_frame, tick_score, start, collide,
      input  run_en, flash, score, hi_score, new_hi, state
   );

   modport slave (
      input  tick_frame, tick_score, start, collide,
      output run_en, flash, score, hi_score, new_hi, state
   );

endinterface
`default_nettype wire

// File: rtl/game_ctrl_tick_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// game_ctrl_tick_counter : counts tick pulses, done pulses on the N-th tick
// Rev 1.0
// ----------------------------------------------------------------------------
module game_ctrl_tick_counter #(
   parameter int N = 10
) (
   input  logic clk,
   input  logic reset,
   input  logic i_clr,
   input  logic i_tick,
   output logic o_done
);

   localparam int               c_cnt_w = $clog2(N + 1);
   localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(N - 1);

   logic [c_cnt_w-1:0] r_cnt;

   // Combinational so the owner can act on the N-th tick in the same clk
   assign o_done = i_tick & ~i_clr & (r_cnt == c_last);

   always_ff @(posedge clk) begin
      if (reset || i_clr) begin
         r_cnt <= '0;
      end else if (i_tick) begin
         r_cnt <= o_done ? '0 : r_cnt + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/game_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// game_ctrl : goose-run game sequencer (IDLE/RUN/HIT/OVER), score and hi-score
// Rev 1.0
// ----------------------------------------------------------------------------
module game_ctrl
   import game_ctrl_pkg::*;
#(
   parameter int SCORE_W      = SCORE_W_DEF,
   parameter int FLASH_FRAMES = 10,
   parameter int HI_DELAY     = 5
) (
   input  logic       clk,
   input  logic       reset,
   game_ctrl_if.slave bus
);

   game_state_t        r_state;
   logic [SCORE_W-1:0] r_score;
   logic [SCORE_W-1:0] r_hi_score;
   logic               r_new_hi;
   logic               r_run_en;
   logic               r_flash;
   logic               r_committed;
   logic               r_start_q;

   logic               w_start_rise;
   logic               w_frm_done;
   logic               w_dly_done;
   logic [SCORE_W-1:0] w_score_inc;

   assign w_start_rise = bus.start & ~r_start_q;
   assign w_score_inc  = (&r_score) ? r_score : r_score + 1'b1;

   // Counters are held clear outside their own state, so each entry starts at 0
   game_ctrl_tick_counter #(.N(FLASH_FRAMES)) u_frm_cnt (
      .clk    (clk),
      .reset  (reset),
      .i_clr  (r_state != GS_HIT),
      .i_tick (bus.tick_frame),
      .o_done (w_frm_done)
   );

   game_ctrl_tick_counter #(.N(HI_DELAY)) u_dly_cnt (
      .clk    (clk),
      .reset  (reset),
      .i_clr  ((r_state != GS_OVER) || r_committed),
      .i_tick (bus.tick_score),
      .o_done (w_dly_done)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= GS_IDLE;
         r_score     <= '0;
         r_hi_score  <= '0;
         r_new_hi    <= 1'b0;
         r_run_en    <= 1'b0;
         r_flash     <= 1'b0;
         r_committed <= 1'b0;
         r_start_q   <= 1'b1;
      end else begin
         r_start_q <= bus.start;
         case (r_state)
            GS_IDLE: begin
               if (w_start_rise) begin
                  r_state     <= GS_RUN;
                  r_score     <= '0;
                  r_new_hi    <= 1'b0;
                  r_run_en    <= 1'b1;
                  r_committed <= 1'b0;
               end
            end
            GS_RUN: begin
               // Collision beats a simultaneous score tick
               if (bus.collide) begin
                  r_state  <= GS_HIT;
                  r_run_en <= 1'b0;
                  r_flash  <= 1'b1;
               end else if (bus.tick_score) begin
                  r_score <= w_score_inc;
               end
            end
            GS_HIT: begin
               if (w_frm_done) begin
                  r_state <= GS_OVER;
                  r_flash <= 1'b0;
               end
            end
            GS_OVER: begin
               if (w_dly_done) begin
                  r_committed <= 1'b1;
                  if (r_score > r_hi_score) begin
                     r_hi_score <= r_score;
                     r_new_hi   <= 1'b1;
                  end
               end else if (w_start_rise && r_committed) begin
                  r_state     <= GS_RUN;
                  r_score     <= '0;
                  r_new_hi    <= 1'b0;
                  r_run_en    <= 1'b1;
                  r_committed <= 1'b0;
               end
            end
            default: r_state <= GS_IDLE;
         endcase
      end
   end

   assign bus.state    = r_state;
   assign bus.score    = r_score;
   assign bus.hi_score = r_hi_score;
   assign bus.new_hi   = r_new_hi;
   assign bus.run_en   = r_run_en;
   assign bus.flash    = r_flash;

endmodule
`default_nettype wire

// File: tb/tb_game_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_game_ctrl : vector table + scoreboard bench for game_ctrl (16- and 4-bit)
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_game_ctrl;

   typedef struct {
      string       nm;
      int          n;
      logic        rst, st, col, tf, ts;
      logic [1:0]  e_state;
      logic [15:0] e_score;
      logic [3:0]  e_score4;
      logic [15:0] e_hi;
      logic        e_new, e_run, e_flash;
   } vec_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0;
   logic collide = 1'b0;
   logic tick_frame = 1'b0;
   logic tick_score = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   vec_t tbl[$];
   vec_t sb[$];

   always #5 clk = ~clk;

   game_ctrl_if #(.SCORE_W(16)) bus16 ();
   game_ctrl_if #(.SCORE_W(4))  bus4 ();

   assign bus16.start      = start;
   assign bus16.collide    = collide;
   assign bus16.tick_frame = tick_frame;
   assign bus16.tick_score = tick_score;
   assign bus4.start       = start;
   assign bus4.collide     = collide;
   assign bus4.tick_frame  = tick_frame;
   assign bus4.tick_score  = tick_score;

   game_ctrl #(.SCORE_W(16), .FLASH_FRAMES(10), .HI_DELAY(5)) u_dut16 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus16)
   );

   game_ctrl #(.SCORE_W(4), .FLASH_FRAMES(10), .HI_DELAY(5)) u_dut4 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus4)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input string nm, input int n,
                               input logic rst, input logic st, input logic col,
                               input logic tf, input logic ts,
                               input int es, input int esc, input int esc4,
                               input int ehi, input logic enew, input logic erun,
                               input logic efl);
      vec_t v;
      v.nm = nm; v.n = n;
      v.rst = rst; v.st = st; v.col = col; v.tf = tf; v.ts = ts;
      v.e_state = es[1:0]; v.e_score = esc[15:0]; v.e_score4 = esc4[3:0];
      v.e_hi = ehi[15:0]; v.e_new = enew; v.e_run = erun; v.e_flash = efl;
      return v;
   endfunction

   // Holds the record's inputs for n clocks, then checks the final outputs
   task automatic apply(input vec_t v);
      vec_t e;
      sb.push_back(v);
      for (int i = 0; i < v.n; i++) begin
         reset = v.rst; start = v.st; collide = v.col;
         tick_frame = v.tf; tick_score = v.ts;
         @(posedge clk);
         #1;
      end
      e = sb.pop_front();
      chk({e.nm, ".state"},  32'(bus16.state),    32'(e.e_state));
      chk({e.nm, ".score"},  32'(bus16.score),    32'(e.e_score));
      chk({e.nm, ".hi"},     32'(bus16.hi_score), 32'(e.e_hi));
      chk({e.nm, ".new_hi"}, 32'(bus16.new_hi),   32'(e.e_new));
      chk({e.nm, ".run_en"}, 32'(bus16.run_en),   32'(e.e_run));
      chk({e.nm, ".flash"},  32'(bus16.flash),    32'(e.e_flash));
      chk({e.nm, ".state4"}, 32'(bus4.state),     32'(e.e_state));
      chk({e.nm, ".score4"}, 32'(bus4.score),     32'(e.e_score4));
      chk({e.nm, ".hi4"},    32'(bus4.hi_score),  32'(e.e_hi[3:0]));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      //            name        n  rs st co tf ts  st sc sc4 hi nw rn fl
      tbl.push_back(mk("rst",      2, 1, 0, 0, 0, 0, 0,  0,  0, 0, 0, 0, 0));
      tbl.push_back(mk("idle_tk", 20, 0, 0, 0, 1, 1, 0,  0,  0, 0, 0, 0, 0));
      tbl.push_back(mk("idle_col", 3, 0, 0, 1, 0, 0, 0,  0,  0, 0, 0, 0, 0));
      tbl.push_back(mk("go1",      1, 0, 1, 0, 0, 0, 1,  0,  0, 0, 0, 1, 0));
      tbl.push_back(mk("run7",     7, 0, 0, 0, 0, 1, 1,  7,  7, 0, 0, 1, 0));
      tbl.push_back(mk("hit",      1, 0, 0, 1, 0, 1, 2,  7,  7, 0, 0, 0, 1));
      tbl.push_back(mk("hit9",     9, 0, 1, 0, 1, 0, 2,  7,  7, 0, 0, 0, 1));
      tbl.push_back(mk("over",     1, 0, 0, 0, 1, 0, 3,  7,  7, 0, 0, 0, 0));
      tbl.push_back(mk("dly4",     4, 0, 0, 0, 0, 1, 3,  7,  7, 0, 0, 0, 0));
      tbl.push_back(mk("commit1",  1, 0, 0, 0, 0, 1, 3,  7,  7, 7, 1, 0, 0));
      tbl.push_back(mk("go2",      1, 0, 1, 0, 0, 0, 1,  0,  0, 7, 0, 1, 0));
      tbl.push_back(mk("run3",     3, 0, 0, 0, 0, 1, 1,  3,  3, 7, 0, 1, 0));
      tbl.push_back(mk("hit2",     1, 0, 0, 1, 0, 0, 2,  3,  3, 7, 0, 0, 1));
      tbl.push_back(mk("over2",   10, 0, 0, 0, 1, 0, 3,  3,  3, 7, 0, 0, 0));
      tbl.push_back(mk("st_dly",   2, 0, 1, 0, 0, 1, 3,  3,  3, 7, 0, 0, 0));
      tbl.push_back(mk("rel",      1, 0, 0, 0, 0, 0, 3,  3,  3, 7, 0, 0, 0));
      tbl.push_back(mk("st_dly2",  1, 0, 1, 0, 0, 0, 3,  3,  3, 7, 0, 0, 0));
      tbl.push_back(mk("commit2",  3, 0, 0, 0, 0, 1, 3,  3,  3, 7, 0, 0, 0));
      tbl.push_back(mk("go3",      1, 0, 1, 0, 0, 0, 1,  0,  0, 7, 0, 1, 0));
      tbl.push_back(mk("sat",     20, 0, 0, 0, 0, 1, 1, 20, 15, 7, 0, 1, 0));
      tbl.push_back(mk("rst_run",  1, 1, 1, 1, 1, 1, 0,  0,  0, 0, 0, 0, 0));
      tbl.push_back(mk("rst_hold", 2, 1, 1, 0, 0, 0, 0,  0,  0, 0, 0, 0, 0));
      tbl.push_back(mk("held",     3, 0, 1, 0, 0, 0, 0,  0,  0, 0, 0, 0, 0));
      tbl.push_back(mk("fall",     1, 0, 0, 0, 0, 0, 0,  0,  0, 0, 0, 0, 0));
      tbl.push_back(mk("rise",     1, 0, 1, 0, 0, 0, 1,  0,  0, 0, 0, 1, 0));

      foreach (tbl[i]) apply(tbl[i]);

      // One-clock output latency on a score tick
      start = 1'b0; tick_score = 1'b1;
      #3;
      chk("lat.before", 32'(bus16.score), 32'd0);
      @(posedge clk); #1;
      chk("lat.after", 32'(bus16.score), 32'd1);

      // Collide + tick together, then further ticks and collides in HIT
      collide = 1'b1; tick_score = 1'b1;
      @(posedge clk); #1;
      chk("pri.state", 32'(bus16.state), 32'd2);
      chk("pri.score", 32'(bus16.score), 32'd1);
      repeat (3) @(posedge clk);
      #1;
      chk("hitfrz.score", 32'(bus16.score), 32'd1);
      chk("hitfrz.state", 32'(bus16.state), 32'd2);
      collide = 1'b0; tick_score = 1'b0;
      @(posedge clk); #1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
